// File: rtl/root_pkg.sv
// Shared definitions for the root_nth block: FSM state encoding and default widths.
package root_pkg;

   localparam int IN_W_DEF   = 10;
   localparam int FRAC_W_DEF = 10;
   localparam int EXP_W_DEF  = 3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_POW  = 2'd1,
      S_CMP  = 2'd2,
      S_OUT  = 2'd3
   } state_e;

endpackage

// File: rtl/root_mul_sat.sv
// Combinational fixed-point multiplier: (a*b)>>FRAC_W, saturated to OUT_W bits.
module root_mul_sat
   import root_pkg::*;
#(
   parameter int OUT_W  = IN_W_DEF + FRAC_W_DEF,
   parameter int FRAC_W = FRAC_W_DEF
) (
   input  logic [OUT_W-1:0] a_i,
   input  logic [OUT_W-1:0] b_i,
   output logic [OUT_W-1:0] p_o,
   output logic             sat_o
);

   logic [2*OUT_W-1:0] prod_s;
   logic [2*OUT_W-1:0] shifted_s;

   // Full-width product, drop the fraction, clamp anything that overflows OUT_W.
   always_comb begin
      prod_s    = {{OUT_W{1'b0}}, a_i} * {{OUT_W{1'b0}}, b_i};
      shifted_s = prod_s >> FRAC_W;
      sat_o     = |shifted_s[2*OUT_W-1:OUT_W];
      if (sat_o) begin
         p_o = {OUT_W{1'b1}};
      end else begin
         p_o = shifted_s[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/root_nth.sv
// root_nth: k-th root of an unsigned integer, result in Q IN_W.FRAC_W, found
// bit by bit (MSB first) by raising each trial value to the k-th power with a
// truncating, saturating multiplier and keeping the bit when trial^k <= X.
// Optional macro ROOT_NTH_EXACT_EN adds the out_exact output.
module root_nth
   import root_pkg::*;
#(
   parameter  int IN_W   = IN_W_DEF,
   parameter  int FRAC_W = FRAC_W_DEF,
   parameter  int EXP_W  = EXP_W_DEF,
   localparam int OUT_W  = IN_W + FRAC_W,
   localparam int IDX_W  = $clog2(OUT_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [EXP_W-1:0] in_exp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_err
`ifdef ROOT_NTH_EXACT_EN
   ,
   output logic             out_exact
`endif
);

   localparam logic [OUT_W-1:0] ONE     = OUT_W'(1);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(OUT_W - 1);

   state_e             state_q, state_d;
   logic [OUT_W-1:0]   x_q, x_d;
   logic [EXP_W-1:0]   k_q, k_d;
   logic [OUT_W-1:0]   y_q, y_d;
   logic [OUT_W-1:0]   t_q, t_d;
   logic [OUT_W-1:0]   p_q, p_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [EXP_W-1:0]   cnt_q, cnt_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic [OUT_W-1:0]   out_data_q, out_data_d;
   logic               out_err_q, out_err_d;

   logic [OUT_W-1:0]   mul_p_s;
   logic               mul_sat_s;
   logic [OUT_W-1:0]   y_keep_s;
   logic [IDX_W-1:0]   idx_dec_s;
   logic [EXP_W-1:0]   cnt_inc_s;
   logic [OUT_W-1:0]   x_in_s;

   root_mul_sat #(
      .OUT_W  (OUT_W),
      .FRAC_W (FRAC_W)
   ) u_mul (
      .a_i   (p_q),
      .b_i   (t_q),
      .p_o   (mul_p_s),
      .sat_o (mul_sat_s)
   );

   assign y_keep_s  = (p_q <= x_q) ? t_q : y_q;
   assign idx_dec_s = idx_q - IDX_W'(1);
   assign cnt_inc_s = cnt_q + EXP_W'(1);
   assign x_in_s    = {in_data, {FRAC_W{1'b0}}};

   // Next-state and datapath updates for the IDLE/POW/CMP/OUT sequencer.
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      k_d         = k_q;
      y_d         = y_q;
      t_d         = t_q;
      p_d         = p_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_err_d   = out_err_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               x_d        = x_in_s;
               k_d        = in_exp;
               y_d        = {OUT_W{1'b0}};
               idx_d      = IDX_TOP;
               in_ready_d = 1'b0;
               if (in_exp == {EXP_W{1'b0}}) begin
                  state_d     = S_OUT;
                  out_valid_d = 1'b1;
                  out_data_d  = {OUT_W{1'b0}};
                  out_err_d   = 1'b1;
               end else if (in_exp == EXP_W'(1)) begin
                  state_d     = S_OUT;
                  out_valid_d = 1'b1;
                  out_data_d  = x_in_s;
                  out_err_d   = 1'b0;
               end else begin
                  state_d = S_POW;
                  t_d     = ONE << IDX_TOP;
                  p_d     = ONE << IDX_TOP;
                  cnt_d   = EXP_W'(1);
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_POW: begin
            p_d   = mul_p_s;
            cnt_d = cnt_inc_s;
            // A saturated power already exceeds any X, so stop raising early.
            if ((cnt_inc_s == k_q) || mul_sat_s) begin
               state_d = S_CMP;
            end else begin
               state_d = S_POW;
            end
         end
         S_CMP: begin
            y_d = y_keep_s;
            if ((p_q == x_q) || (idx_q == {IDX_W{1'b0}})) begin
               state_d     = S_OUT;
               out_valid_d = 1'b1;
               out_data_d  = y_keep_s;
               out_err_d   = 1'b0;
            end else begin
               state_d = S_POW;
               idx_d   = idx_dec_s;
               t_d     = y_keep_s | (ONE << idx_dec_s);
               p_d     = y_keep_s | (ONE << idx_dec_s);
               cnt_d   = EXP_W'(1);
            end
         end
         S_OUT: begin
            if (out_ready) begin
               state_d     = S_IDLE;
               in_ready_d  = 1'b1;
               out_valid_d = 1'b0;
               out_data_d  = {OUT_W{1'b0}};
               out_err_d   = 1'b0;
            end else begin
               state_d = S_OUT;
            end
         end
         default: begin
            state_d     = S_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_data_d  = {OUT_W{1'b0}};
            out_err_d   = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers; reset aborts any computation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         x_q         <= {OUT_W{1'b0}};
         k_q         <= {EXP_W{1'b0}};
         y_q         <= {OUT_W{1'b0}};
         t_q         <= {OUT_W{1'b0}};
         p_q         <= {OUT_W{1'b0}};
         idx_q       <= {IDX_W{1'b0}};
         cnt_q       <= {EXP_W{1'b0}};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= {OUT_W{1'b0}};
         out_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         k_q         <= k_d;
         y_q         <= y_d;
         t_q         <= t_d;
         p_q         <= p_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_err_q   <= out_err_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_err   = out_err_q;

`ifdef ROOT_NTH_EXACT_EN
   logic exact_q, exact_d;

   // Exact flag: captured when the result is loaded, cleared once it retires.
   always_comb begin
      exact_d = exact_q;
      if ((state_q == S_IDLE) && (state_d == S_OUT)) begin
         exact_d = (in_exp == EXP_W'(1));
      end else if ((state_q == S_CMP) && (state_d == S_OUT)) begin
         exact_d = (p_q == x_q);
      end else if (state_d != S_OUT) begin
         exact_d = 1'b0;
      end else begin
         exact_d = exact_q;
      end
   end

   // Exact flag register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exact_q <= 1'b0;
      end else begin
         exact_q <= exact_d;
      end
   end

   assign out_exact = exact_q;
`endif

endmodule

// File: tb/tb_root_nth.sv
// Self-checking bench for root_nth: expected results are queued at request
// time from an independent reference model and compared when the DUT responds.
module tb_root_nth;

   localparam int    IN_W   = 10;
   localparam int    FRAC_W = 10;
   localparam int    EXP_W  = 3;
   localparam int    OUT_W  = IN_W + FRAC_W;
   localparam longint PMAX  = (64'd1 << OUT_W) - 64'd1;

   typedef struct packed {
      logic [OUT_W-1:0] data;
      logic             err;
      logic             exact;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic [EXP_W-1:0] in_exp;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_err;
`ifdef ROOT_NTH_EXACT_EN
   logic             out_exact;
`endif

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb_q[$];

   root_nth dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_exp    (in_exp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err)
`ifdef ROOT_NTH_EXACT_EN
      ,
      .out_exact (out_exact)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Truncated, saturating iterated power y^k in Q.FRAC_W.
   function automatic longint tpow(input longint y, input int k);
      longint p;
      p = y;
      for (int i = 1; i < k; i++) begin
         p = (p * y) >> FRAC_W;
         if (p > PMAX) begin
            p = PMAX;
            break;
         end
      end
      return p;
   endfunction

   // Reference: largest y with tpow(y,k) <= X, seeded from a real-valued root.
   function automatic exp_t model(input int x, input int k);
      exp_t   e;
      longint xx;
      longint y;
      real    r;
      xx      = longint'(x) << FRAC_W;
      e.err   = 1'b0;
      e.exact = 1'b0;
      e.data  = '0;
      if (k == 0) begin
         e.err = 1'b1;
      end else if (k == 1) begin
         e.data  = xx[OUT_W-1:0];
         e.exact = 1'b1;
      end else begin
         r = $pow(real'(x), 1.0 / real'(k)) * 1024.0;
         y = longint'($rtoi(r));
         if (y > PMAX) y = PMAX;
         if (y < 0) y = 0;
         while (y < PMAX && tpow(y + 1, k) <= xx) y++;
         while (y > 0 && tpow(y, k) > xx) y--;
         e.data  = y[OUT_W-1:0];
         e.exact = (tpow(y, k) == xx);
      end
      return e;
   endfunction

   // One request/response, with 'stall' cycles of out_ready low while the result waits.
   task automatic run_one(input int x, input int k, input int stall, input int want);
      exp_t             e;
      int               lat;
      logic [OUT_W-1:0] held;
      bit               moved;
      lat = 0;
      while (!in_ready && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check_val("in_ready_before_req", in_ready, 1);
      in_data  = x[IN_W-1:0];
      in_exp   = k[EXP_W-1:0];
      in_valid = 1'b1;
      sb_q.push_back(model(x, k));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = '0;
      in_exp   = '0;
      @(negedge clk);
      lat = 1;
      while (!out_valid && lat < OUT_W * k + 4) begin
         if (in_ready) check_val("in_ready_busy", in_ready, 0);
         @(negedge clk);
         lat++;
      end
      check_val("out_valid_seen", out_valid, 1);
      if (k <= 1) check_val("latency_short", lat, 1);
      else        check_val("latency_bound", (lat <= OUT_W * k + 1), 1);
      held  = out_data;
      moved = 1'b0;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0) moved = 1'b1;
      end
      if (stall > 0) check_val("hold_during_stall", moved, 0);
      out_ready = 1'b1;
      check_val("in_ready_in_retire", in_ready, 0);
      check_val("scoreboard_depth", sb_q.size(), 1);
      e = sb_q.pop_front();
      check_val("out_data", out_data, e.data);
      check_val("out_err", out_err, e.err);
`ifdef ROOT_NTH_EXACT_EN
      check_val("out_exact", out_exact, e.exact);
`endif
      if (want >= 0) check_val("spec_vector", out_data, want);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check_val("idle_out_valid", out_valid, 0);
      check_val("idle_out_data_zero", out_data, 0);
      check_val("idle_in_ready", in_ready, 1);
   endtask

   initial begin
      bit seen;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_exp    = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_in_ready", in_ready, 1);
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_out_data", out_data, 0);
      check_val("rst_out_err", out_err, 0);
      rst = 1'b0;
      @(negedge clk);

      run_one(16, 2, 0, 32'h01000);
      run_one(2, 2, 0, 32'h005A8);
      run_one(1000, 3, 0, 32'h02800);
      run_one(5, 0, 0, 32'h00000);
      run_one(5, 1, 0, 32'h01400);
      run_one(16, 2, 20, 32'h01000);
      run_one(1023, 7, 0, -1);
      run_one(1, 5, 0, 32'h00400);

      // Abort a long computation with an asynchronous reset.
      in_data  = 10'd1023;
      in_exp   = 3'd7;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      check_val("busy_before_abort", in_ready, 0);
      #2;
      rst = 1'b1;
      #1;
      check_val("abort_in_ready", in_ready, 1);
      check_val("abort_out_valid", out_valid, 0);
      check_val("abort_out_data", out_data, 0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check_val("abort_no_result", seen, 0);
      run_one(16, 2, 0, 32'h01000);

      for (int i = 0; i < 12; i++) begin
         run_one(int'($urandom_range(1, 1023)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 3)), -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/root_nth.md
ROOT_NTH -- requirements
Module: root_nth

Interface
REQ-001 The block SHALL have parameter IN_W, default 10, meaning integer bits of the radicand.
REQ-002 The block SHALL have parameter FRAC_W, default 10, meaning fraction bits of the result (Q IN_W.FRAC_W).
REQ-003 The block SHALL have parameter EXP_W, default 3, meaning exponent width; OUT_W = IN_W+FRAC_W.
REQ-004 Port clk: input, 1 bit, the single clock; all flops rise on posedge clk.
REQ-005 Port rst: input, 1 bit, asynchronous active-high reset.
REQ-006 Port in_valid: input, 1 bit, request present.
REQ-007 Port in_ready: output, 1 bit, block can accept a request.
REQ-008 Port in_data: input, IN_W bits, unsigned integer radicand x.
REQ-009 Port in_exp: input, EXP_W bits, root order k.
REQ-010 Port out_valid: output, 1 bit, result present.
REQ-011 Port out_ready: input, 1 bit, consumer accepts result.
REQ-012 Port out_data: output, OUT_W bits, root in Q IN_W.FRAC_W.
REQ-013 Port out_err: output, 1 bit, set with result when k==0.

Function
REQ-014 The block SHALL implement states IDLE, POW, CMP, OUT.
REQ-015 IDLE: in_ready=1; on in_valid&&in_ready, capture X={in_data,FRAC_W zeros}, k, set y=0, idx=OUT_W-1.
REQ-016 Accept with k==0 SHALL go to OUT with out_data=0, out_err=1; k==1 SHALL go to OUT with out_data=X, out_err=0.
REQ-017 Accept with k>=2 SHALL go to POW with trial t=1<<idx, p=t, cnt=1.
REQ-018 POW, per cycle: p <= (p*t)>>FRAC_W using a 2*OUT_W-bit product, cnt++; if the shifted product exceeds 2^OUT_W-1, p <= all-ones (saturate).
REQ-019 POW SHALL go to CMP in the cycle p reaches t^k (cnt==k after update) or saturates.
REQ-020 CMP: if p<=X, y<=t; if p==X or idx==0, go to OUT; else idx--, t=y|(1<<idx), p=t, cnt=1, go to POW.
REQ-021 The result SHALL be the largest y whose truncated iterated power per REQ-018 is <=X.
REQ-022 Latency from accept to out_valid SHALL be 1 cycle for k<=1 and at most OUT_W*k cycles otherwise.
REQ-023 in_ready SHALL be 0 in POW, CMP and OUT; in_valid is ignored there.
REQ-024 OUT: out_valid=1; out_data/out_err SHALL hold stable until out_valid&&out_ready, then go to IDLE.
REQ-025 in_ready SHALL not assert in the OUT-retire cycle; the next accept is earliest one cycle later.
REQ-026 out_data SHALL be driven 0 whenever out_valid is 0.

Reset
REQ-027 rst SHALL asynchronously force IDLE, in_ready=1, out_valid=0, out_data=0, out_err=0, all datapath registers 0.
REQ-028 Reset mid-operation SHALL abort the computation with no result emitted.

Configuration
REQ-029 With ROOT_NTH_EXACT_EN defined, the block SHALL add output out_exact (1 bit), valid with out_valid, equal to 1 when the final compared p==X (early exit, or k==1); without the macro the port and its logic SHALL not exist.

Structure
REQ-030 State encoding enum and the default widths SHALL live in shared package root_pkg.
REQ-031 The saturating truncated multiplier SHALL be sub-module root_mul_sat (combinational, parameterised OUT_W, FRAC_W).

Verification
REQ-032 x=16, k=2 -> out_data=0x01000, out_err=0, early exit before idx 0.
REQ-033 x=2, k=2 -> out_data=0x005A8 (1.41406).
REQ-034 x=1000, k=3 -> out_data=0x02800; with ROOT_NTH_EXACT_EN, out_exact=1.
REQ-035 x=5, k=0 -> 1 cycle later out_valid=1, out_err=1, out_data=0; k=1, x=5 -> out_data=0x01400.
REQ-036 x=16, k=2 with out_ready low 20 cycles -> out_data held 0x01000, in_ready 0 throughout, retire on out_ready.
REQ-037 Assert rst mid-POW for x=1023, k=7 -> immediate IDLE, out_valid stays 0; a new x=16, k=2 then returns 0x01000.
